alu_control_md: RTL and testbench



---
 rtl/alu_control_md.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_control_md.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_md.sv
// ALU control decoder with an iterative multiply/divide sequencer and HI/LO registers.
// Decode is purely combinational; mult/div run one bit per cycle for WIDTH cycles.
module alu_control_md #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned AOP_W  = 3,
  parameter int unsigned ALUS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AOP_W-1:0]  aop,
  input  logic [5:0]        func,
  input  logic              md_valid,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  output logic [ALUS_W-1:0] alu_s,
  output logic              illegal,
  output logic              md_busy,
  output logic              md_done,
  output logic              stall,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [AOP_W-1:0] AopR   = AOP_W'(3'b001);
  localparam logic [AOP_W-1:0] AopAdd = AOP_W'(3'b110);
  localparam logic [AOP_W-1:0] AopSlt = AOP_W'(3'b010);
  localparam logic [AOP_W-1:0] AopAnd = AOP_W'(3'b011);
  localparam logic [AOP_W-1:0] AopOr  = AOP_W'(3'b100);
  localparam logic [AOP_W-1:0] AopSub = AOP_W'(3'b101);

  localparam logic [5:0] FnSll   = 6'b000000;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  // ---------------------------------------------------------------------------
  // ALU select decode
  // ---------------------------------------------------------------------------
  logic [3:0] alu_sel;

  always_comb begin
    alu_sel = AluAnd;
    illegal = 1'b0;
    case (aop)
      AopR: begin
        case (func)
          FnAdd: alu_sel = AluAdd;
          FnSub: alu_sel = AluSub;
          FnAnd: alu_sel = AluAnd;
          FnOr:  alu_sel = AluOr;
          FnNor: alu_sel = AluNor;
          FnSlt: alu_sel = AluSlt;
          FnSll, FnMult, FnMultu, FnDiv, FnDivu, FnMfhi, FnMflo: alu_sel = AluAnd;
          default: illegal = 1'b1;
        endcase
      end
      AopAdd:  alu_sel = AluAdd;
      AopSlt:  alu_sel = AluSlt;
      AopAnd:  alu_sel = AluAnd;
      AopOr:   alu_sel = AluOr;
      AopSub:  alu_sel = AluSub;
      default: illegal = 1'b1;
    endcase
  end

  assign alu_s = ALUS_W'(alu_sel);

  // ---------------------------------------------------------------------------
  // Multiply/divide sequencer
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       opb_q, opb_d;
  logic                   neg_q, neg_d;
  logic                   rneg_q, rneg_d;
  logic                   divz_q, divz_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  logic                   r_valid;
  logic                   is_md_op;
  logic                   is_hilo_op;
  logic                   issue;
  logic                   last_iter;
  logic                   op_signed;
  logic                   a_sgn, b_sgn;
  logic [WIDTH-1:0]       a_mag, b_mag;

  assign r_valid    = (aop == AopR) && md_valid;
  assign is_md_op   = (func == FnMult) || (func == FnMultu) || (func == FnDiv) ||
                      (func == FnDivu);
  assign is_hilo_op = is_md_op || (func == FnMfhi) || (func == FnMflo);
  assign issue      = r_valid && is_md_op && ((state_q == StIdle) || (state_q == StDone));
  assign last_iter  = (cnt_q == CntW'(WIDTH - 1));

  // func[0] clear selects the signed variant; func[1] selects divide.
  assign op_signed = ~func[0];
  assign a_sgn     = op_signed && op_a[WIDTH-1];
  assign b_sgn     = op_signed && op_b[WIDTH-1];
  assign a_mag     = a_sgn ? -op_a : op_a;
  assign b_mag     = b_sgn ? -op_b : op_b;

  // Shift-add step: acc holds {partial sum, remaining multiplier bits}.
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next;
  logic [2*WIDTH-1:0]     mul_res;

  // Restoring step: acc holds {remainder, dividend bits / quotient bits}.
  logic [WIDTH:0]         div_shift;
  logic                   div_ge;
  logic [WIDTH-1:0]       div_rem;
  logic [2*WIDTH-1:0]     div_next;
  logic [WIDTH-1:0]       quo_res;
  logic [WIDTH-1:0]       rem_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    mul_res  = neg_q ? -mul_next : mul_next;

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
    quo_res   = divz_q ? '1 : (neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0]);
    rem_res   = rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          state_d = StDone;
          cnt_d   = '0;
          hi_d    = mul_res[2*WIDTH-1:WIDTH];
          lo_d    = mul_res[WIDTH-1:0];
        end
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          state_d = StDone;
          cnt_d   = '0;
          hi_d    = rem_res;
          lo_d    = quo_res;
        end
      end
      StDone:  state_d = StIdle;
      default: ;
    endcase

    if (issue) begin
      state_d = func[1] ? StDiv : StMul;
      cnt_d   = '0;
      acc_d   = {{WIDTH{1'b0}}, a_mag};
      opb_d   = b_mag;
      neg_d   = a_sgn ^ b_sgn;
      rneg_d  = a_sgn;
      divz_d  = func[1] && (op_b == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md_busy = (state_q == StMul) || (state_q == StDiv);
  assign md_done = (state_q == StDone);
  assign stall   = md_busy && r_valid && is_hilo_op;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: a 32-bit and an 8-bit instance share control inputs.
module tb_alu_control_md;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  aop;
  logic [5:0]  func;
  logic        md_valid;
  logic [31:0] op_a, op_b;
  logic [7:0]  op_a8, op_b8;

  logic [3:0]  alu_s, alu_s8;
  logic        illegal, illegal8;
  logic        md_busy, md_busy8;
  logic        md_done, md_done8;
  logic        stall, stall8;
  logic [31:0] hi, lo;
  logic [7:0]  hi8, lo8;

  int n_tests = 0;
  int n_fail  = 0;

  // Results captured by run_op
  int          lat32, lat8, busy32;
  logic        mid_ok;
  logic [31:0] r_hi, r_lo, last_hi, last_lo;
  logic [7:0]  r_hi8, r_lo8;

  alu_control_md #(.WIDTH(32), .AOP_W(3), .ALUS_W(4)) u_dut (
    .clk(clk), .rst(rst), .aop(aop), .func(func), .md_valid(md_valid),
    .op_a(op_a), .op_b(op_b), .alu_s(alu_s), .illegal(illegal),
    .md_busy(md_busy), .md_done(md_done), .stall(stall), .hi(hi), .lo(lo)
  );

  alu_control_md #(.WIDTH(8), .AOP_W(3), .ALUS_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .aop(aop), .func(func), .md_valid(md_valid),
    .op_a(op_a8), .op_b(op_b8), .alu_s(alu_s8), .illegal(illegal8),
    .md_busy(md_busy8), .md_done(md_done8), .stall(stall8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  // Expected {illegal, alu_s} from the decode table.
  function automatic logic [4:0] exp_dec(input logic [2:0] a, input logic [5:0] f);
    case (a)
      3'b001: begin
        case (f)
          6'b100000: return 5'b0_0010;
          6'b100010: return 5'b0_0110;
          6'b100100: return 5'b0_0000;
          6'b100101: return 5'b0_0001;
          6'b100111: return 5'b0_1100;
          6'b101010: return 5'b0_0111;
          6'b000000, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
          6'b010000, 6'b010010: return 5'b0_0000;
          default: return 5'b1_0000;
        endcase
      end
      3'b110:  return 5'b0_0010;
      3'b010:  return 5'b0_0111;
      3'b011:  return 5'b0_0000;
      3'b100:  return 5'b0_0001;
      3'b101:  return 5'b0_0110;
      default: return 5'b1_0000;
    endcase
  endfunction

  task automatic idle_inputs();
    aop = 3'b110; func = 6'b000000; md_valid = 1'b0;
    op_a = '0; op_b = '0; op_a8 = '0; op_b8 = '0;
  endtask

  // Issue one op on both instances, then track completion.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] a8, input logic [7:0] b8);
    @(posedge clk); #1;
    aop = 3'b001; func = f; md_valid = 1'b1; op_a = a; op_b = b; op_a8 = a8; op_b8 = b8;
    @(posedge clk); #1;
    idle_inputs();
    lat32 = 0; lat8 = 0; busy32 = 0; mid_ok = 1'b1;
    for (int n = 1; n <= 60 && lat32 == 0; n++) begin
      @(negedge clk);
      if (md_busy) busy32++;
      if (n == 5 && (hi !== last_hi || lo !== last_lo)) mid_ok = 1'b0;
      if (md_done8 && lat8 == 0) begin lat8 = n; r_hi8 = hi8; r_lo8 = lo8; end
      if (md_done) begin lat32 = n; r_hi = hi; r_lo = lo; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({md_busy, md_done, stall, md_busy8, md_done8} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000",
               {md_busy, md_done, stall, md_busy8, md_done8});
    end
    n_tests++;
    if ({hi, lo, hi8, lo8} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_hilo: got %h %h %h %h want zeros", hi, lo, hi8, lo8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_hi = '0; last_lo = '0;
  endtask

  task automatic test_decode();
    int errs = 0;
    md_valid = 1'b0;
    for (int ai = 0; ai < 8; ai++) begin
      for (int fi = 0; fi < 64; fi++) begin
        aop = 3'(ai); func = 6'(fi);
        #1;
        n_tests++;
        if ({illegal, alu_s} !== exp_dec(3'(ai), 6'(fi))) begin
          n_fail++; errs++;
          if (errs < 8)
            $display("FAIL decode aop=%b func=%b: got %b want %b", aop, func,
                     {illegal, alu_s}, exp_dec(3'(ai), 6'(fi)));
        end
      end
    end
    aop = 3'b001; func = 6'b100111; #1;
    n_tests++;
    if ({illegal, alu_s} !== 5'b0_1100) begin
      n_fail++; $display("FAIL decode_nor: got %b want 01100", {illegal, alu_s});
    end
    aop = 3'b111; func = 6'b100000; #1;
    n_tests++;
    if (illegal !== 1'b1 || alu_s !== 4'b0000) begin
      n_fail++; $display("FAIL decode_aop7: got ill=%b s=%b want 1 0000", illegal, alu_s);
    end
    idle_inputs();
  endtask

  task automatic test_mult();
    // -3 * 7 signed; 8-bit: -128 * -1 signed = 128
    run_op(6'b011000, 32'hFFFF_FFFD, 32'd7, 8'h80, 8'hFF);
    n_tests++;
    if (lat32 != 33) begin n_fail++; $display("FAIL mult_latency: got %0d want 33", lat32); end
    n_tests++;
    if (busy32 != 32) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 32", busy32); end
    n_tests++;
    if (mid_ok !== 1'b1) begin n_fail++; $display("FAIL mult_hilo_hold: got changed want held"); end
    n_tests++;
    if ({r_hi, r_lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_fail++; $display("FAIL mult_signed: got %h_%h want ffffffff_ffffffeb", r_hi, r_lo);
    end
    n_tests++;
    if (lat8 != 9 || {r_hi8, r_lo8} !== 16'h0080) begin
      n_fail++; $display("FAIL mult8_signed: got lat=%0d %h_%h want 9 00_80", lat8, r_hi8, r_lo8);
    end
    last_hi = 32'hFFFF_FFFF; last_lo = 32'hFFFF_FFEB;

    run_op(6'b011001, 32'hFFFF_FFFF, 32'd2, 8'hFF, 8'hFF);
    n_tests++;
    if ({r_hi, r_lo} !== 64'h0000_0001_FFFF_FFFE) begin
      n_fail++; $display("FAIL multu: got %h_%h want 00000001_fffffffe", r_hi, r_lo);
    end
    n_tests++;
    if (lat8 != 9 || {r_hi8, r_lo8} !== 16'hFE01) begin
      n_fail++; $display("FAIL multu8: got lat=%0d %h_%h want 9 fe_01", lat8, r_hi8, r_lo8);
    end
    last_hi = 32'h0000_0001; last_lo = 32'hFFFF_FFFE;
  endtask

  task automatic test_div();
    // -7 / 2 signed; 8-bit: MIN / -1
    run_op(6'b011010, 32'hFFFF_FFF9, 32'd2, 8'h80, 8'hFF);
    n_tests++;
    if (lat32 != 33 || {r_hi, r_lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_fail++; $display("FAIL div_signed: got lat=%0d %h_%h want 33 ffffffff_fffffffd",
                         lat32, r_hi, r_lo);
    end
    n_tests++;
    if ({r_hi8, r_lo8} !== 16'h0080) begin
      n_fail++; $display("FAIL div8_min_neg1: got %h_%h want 00_80", r_hi8, r_lo8);
    end
    last_hi = 32'hFFFF_FFFF; last_lo = 32'hFFFF_FFFD;

    // 100 / 0 unsigned; 8-bit: 100 / 7 unsigned
    run_op(6'b011011, 32'd100, 32'd0, 8'd100, 8'd7);
    n_tests++;
    if (lat32 != 33 || {r_hi, r_lo} !== 64'h0000_0064_FFFF_FFFF) begin
      n_fail++; $display("FAIL divu_by_zero: got lat=%0d %h_%h want 33 00000064_ffffffff",
                         lat32, r_hi, r_lo);
    end
    n_tests++;
    if ({r_hi8, r_lo8} !== 16'h020E) begin
      n_fail++; $display("FAIL divu8: got %h_%h want 02_0e", r_hi8, r_lo8);
    end
    last_hi = 32'h0000_0064; last_lo = 32'hFFFF_FFFF;

    // MIN / -1 signed; 8-bit: -5 / 0 signed
    run_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 8'hFB, 8'h00);
    n_tests++;
    if ({r_hi, r_lo} !== 64'h0000_0000_8000_0000) begin
      n_fail++; $display("FAIL div_min_neg1: got %h_%h want 00000000_80000000", r_hi, r_lo);
    end
    n_tests++;
    if (lat8 != 9 || {r_hi8, r_lo8} !== 16'hFBFF) begin
      n_fail++; $display("FAIL div8_signed_by_zero: got lat=%0d %h_%h want 9 fb_ff",
                         lat8, r_hi8, r_lo8);
    end
    last_hi = 32'h0; last_lo = 32'h8000_0000;
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    int lat = 0;
    @(posedge clk); #1;
    aop = 3'b001; func = 6'b011000; md_valid = 1'b1; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    // cycles 1-3: add (no stall), 4-8: mflo, 9 onward: second mult held by stall
    aop = 3'b001; func = 6'b100000; md_valid = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c <= 32) begin
        if (md_busy !== 1'b1 || stall !== (c > 3)) begin
          errs++;
          if (errs < 4) $display("FAIL b2b_stall c=%0d: got busy=%b stall=%b want 1 %b",
                                 c, md_busy, stall, (c > 3));
        end
      end else begin
        if (md_done !== 1'b1 || stall !== 1'b0 || hi !== 32'h0 || lo !== 32'h1E) begin
          errs++;
          $display("FAIL b2b_done: got done=%b stall=%b %h_%h want 1 0 00000000_0000001e",
                   md_done, stall, hi, lo);
        end
      end
      @(posedge clk); #1;
      if (c == 3) func = 6'b010010;
      if (c == 8) begin func = 6'b011000; op_a = 32'h8000_0000; op_b = 32'd2; end
      if (c == 33) idle_inputs();
    end
    n_tests++;
    if (errs != 0) begin n_fail++; $display("FAIL b2b_first: got %0d errors want 0", errs); end
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clk);
      if (md_done) begin lat = n; r_hi = hi; r_lo = lo; end
    end
    n_tests++;
    if (lat != 33 || {r_hi, r_lo} !== 64'hFFFF_FFFF_0000_0000) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d %h_%h want 33 ffffffff_00000000",
                         lat, r_hi, r_lo);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done = 1'b0;
    @(posedge clk); #1;
    aop = 3'b001; func = 6'b011011; md_valid = 1'b1; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    idle_inputs();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (md_busy !== 1'b0 || md_done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: got busy=%b done=%b %h_%h want 0 0 zeros",
                         md_busy, md_done, hi, lo);
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (md_done) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_done: got 1 want 0"); end
  endtask

  task automatic test_reset_priority();
    logic bad = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    aop = 3'b001; func = 6'b011000; md_valid = 1'b1; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (md_busy !== 1'b0 || md_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_priority: got busy=%b done=%b want 0 0", md_busy, md_done);
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (md_done || hi !== 32'h0 || lo !== 32'h0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL reset_priority_dropped: got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_back_to_back();
    test_reset_mid();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
